debounce_multi: RTL

Parametrised multi-channel switch/button debouncer for cape GPIO inputs (robotics buttons, limit switches, encoder index lines). Each channel has its own 2-FF synchroniser and stability counter. A channel's output changes only after its input has held a new level for LIMIT consecutive cycles. Single-cycle rise/fall event strobes are provided for the interrupt and event logic downstream.

---
 rtl/debounce_multi.sv | 88 ++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel 2-FF synchroniser, stability counter and rise/fall strobes.
// Optional macro DEBOUNCE_RUNTIME_LIMIT_EN adds a shared run-time limit_in port that replaces LIMIT.
module debounce_multi #(
  parameter int unsigned          CHANNELS    = 4,
  parameter int unsigned          COUNT_WIDTH = 16,
  parameter int unsigned          LIMIT       = 32768,
  parameter logic [CHANNELS-1:0]  RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [CHANNELS-1:0]    switch_in,
`ifdef DEBOUNCE_RUNTIME_LIMIT_EN
  input  logic [COUNT_WIDTH-1:0] limit_in,
`endif
  output logic [CHANNELS-1:0]    switch_out,
  output logic [CHANNELS-1:0]    rise_pulse,
  output logic [CHANNELS-1:0]    fall_pulse,
  output logic                   any_change
);

  // LIMIT-1 must be representable in the counter
  if (LIMIT < 1 || 64'(LIMIT) > (64'(1) << COUNT_WIDTH)) begin : g_limit_check
    $error("debounce_multi: LIMIT must satisfy 1 <= LIMIT <= 2**COUNT_WIDTH");
  end

  logic [CHANNELS-1:0]    sync1_q;
  logic [CHANNELS-1:0]    sync2_q;
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]    out_d;
  logic [CHANNELS-1:0]    rise_d;
  logic [CHANNELS-1:0]    fall_d;
  logic                   any_d;
  logic [COUNT_WIDTH-1:0] limit_m1;

  // Terminal count compared against (limit - 1); a zero run-time limit behaves as 1
`ifdef DEBOUNCE_RUNTIME_LIMIT_EN
  always_comb begin
    limit_m1 = '0;
    if (limit_in != '0) begin
      limit_m1 = limit_in - COUNT_WIDTH'(1);
    end
  end
`else
  assign limit_m1 = COUNT_WIDTH'(LIMIT - 1);
`endif

  // Next-state: count while the synchronised level disagrees, accept at the limit
  always_comb begin
    cnt_d  = '{default: '0};
    out_d  = switch_out;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (sync2_q[i] != switch_out[i]) begin
        if (cnt_q[i] >= limit_m1) begin
          out_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= RESET_VALUE;
      sync2_q    <= RESET_VALUE;
      cnt_q      <= '{default: '0};
      switch_out <= RESET_VALUE;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_change <= 1'b0;
    end else begin
      sync1_q    <= switch_in;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      switch_out <= out_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      any_change <= any_d;
    end
  end

endmodule
